// File: rtl/mult_comp_pipe.sv
// Pipelined W x W multiplier: operand regs, AND / Baugh-Wooley partial products,
// Dadda column compression registered every REG_EVERY levels, registered final add.
module mult_comp_pipe #(
  parameter int W         = 16,
  parameter int REG_EVERY = 2,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_signed,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   out_prod,
  output logic [TAG_W-1:0] out_tag
);

  function automatic int dadda(input int i);
    int d;
    d = 2;
    for (int n = 0; n < i; n++) d = (d * 3) / 2;
    return d;
  endfunction

  function automatic int calc_levels(input int w);
    int l;
    l = 0;
    for (int i = 0; i < 16; i++) if (dadda(l) < w) l++;
    return l;
  endfunction

  localparam int LEVELS = calc_levels(W);

  // Bit matrix indexed [column][row]; rows at or above the column height are zero.
  typedef logic [2*W-1:0][W-1:0] mat_t;
  typedef logic [2*W-1:0][7:0]   hgt_t;

  // One Dadda level: reduce every column (including carries arriving from the
  // column below at this level) to at most d bits. Carries out of the top column drop.
  function automatic void reduce_level(input mat_t m, input hgt_t h, input int d,
                                       output mat_t mo, output hgt_t ho);
    int   hk, p, tot, r;
    logic s, c;
    mo = '0;
    ho = '0;
    for (int k = 0; k < 2*W; k++) begin
      hk  = int'(h[k]);
      p   = 0;
      tot = hk + int'(ho[k]);
      for (int n = 0; n < W; n++) begin
        if (tot > d && hk - p >= 2) begin
          if (tot - d >= 2 && hk - p >= 3) begin
            s = m[k][p] ^ m[k][p+1] ^ m[k][p+2];
            c = (m[k][p] & m[k][p+1]) | (m[k][p+2] & (m[k][p] ^ m[k][p+1]));
            p   = p + 3;
            tot = tot - 2;
          end else begin
            s = m[k][p] ^ m[k][p+1];
            c = m[k][p] & m[k][p+1];
            p   = p + 2;
            tot = tot - 1;
          end
          r = int'(ho[k]);
          mo[k][r] = s;
          ho[k] = ho[k] + 8'd1;
          if (k < 2*W-1) begin
            r = int'(ho[k+1]);
            mo[k+1][r] = c;
            ho[k+1] = ho[k+1] + 8'd1;
          end
        end
      end
      for (int n = 0; n < W; n++) begin
        if (p + n < hk) begin
          r = int'(ho[k]);
          mo[k][r] = m[k][p+n];
          ho[k] = ho[k] + 8'd1;
        end
      end
    end
  endfunction

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic             s0_vld;
  logic             s0_sgn;
  logic [W-1:0]     s0_a;
  logic [W-1:0]     s0_b;
  logic [TAG_W-1:0] s0_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s0_vld <= 1'b0;
    else if (adv) s0_vld <= in_valid;
  end

  // Operands load only on a real transfer so idle-bus garbage never enters the datapath.
  always_ff @(posedge clk) begin
    if (adv && in_valid) begin
      s0_a   <= in_a;
      s0_b   <= in_b;
      s0_sgn <= in_signed;
      s0_tag <= in_tag;
    end
  end

  for (genvar j = 0; j <= LEVELS; j++) begin : lvl
    mat_t             q_mat;
    hgt_t             q_h;
    logic             q_vld;
    logic [TAG_W-1:0] q_tag;

    if (j == 0) begin : g_pp
      // Baugh-Wooley constants sit in the spare top slot of column W and in column 2W-1.
      always_comb begin
        q_mat = '0;
        q_h   = '0;
        for (int k = 0; k < 2*W; k++)
          q_h[k] = 8'(((k < W) ? k + 1 : 2*W - 1 - k) + ((k == W || k == 2*W-1) ? 1 : 0));
        for (int ii = 0; ii < W; ii++)
          for (int jj = 0; jj < W; jj++)
            q_mat[ii+jj][(ii + jj < W) ? ii : W - 1 - jj] =
              (s0_a[ii] & s0_b[jj]) ^ (s0_sgn & ((ii == W-1) != (jj == W-1)));
        q_mat[W][W-1]   = s0_sgn;
        q_mat[2*W-1][0] = s0_sgn;
      end
      assign q_vld = s0_vld;
      assign q_tag = s0_tag;
    end else begin : g_red
      localparam int TGT = dadda(LEVELS - j);
      mat_t d_mat;
      hgt_t d_h;

      always_comb reduce_level(lvl[j-1].q_mat, lvl[j-1].q_h, TGT, d_mat, d_h);
      assign q_h = d_h;

      if ((j % REG_EVERY == 0) || (j == LEVELS)) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) q_vld <= 1'b0;
          else if (adv) q_vld <= lvl[j-1].q_vld;
        end
        always_ff @(posedge clk) begin
          if (adv) begin
            q_mat <= d_mat;
            q_tag <= lvl[j-1].q_tag;
          end
        end
      end else begin : g_comb
        assign q_mat = d_mat;
        assign q_vld = lvl[j-1].q_vld;
        assign q_tag = lvl[j-1].q_tag;
      end
    end
  end

  logic [2*W-1:0] row0, row1;
  always_comb begin
    row0 = '0;
    row1 = '0;
    for (int k = 0; k < 2*W; k++) begin
      row0[k] = lvl[LEVELS].q_mat[k][0];
      row1[k] = lvl[LEVELS].q_mat[k][1];
    end
  end

  logic unused_ok;
  assign unused_ok = ^{lvl[LEVELS].q_h, lvl[LEVELS].q_mat};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_prod  <= '0;
      out_tag   <= '0;
    end else if (adv) begin
      out_valid <= lvl[LEVELS].q_vld;
      if (lvl[LEVELS].q_vld) begin
        out_prod <= row0 + row1;
        out_tag  <= lvl[LEVELS].q_tag;
      end
    end
  end

endmodule

// File: tb/tb_mult_comp_pipe.sv
// Bench for mult_comp_pipe: directed W=16 vectors and corner sequences, then a random
// sweep over three parameterisations sharing one stimulus stream with per-instance scoreboards.
module tb_mult_comp_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_signed = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] st_a = '0, st_b = '0;
  logic [3:0]  in_tag = '0;

  logic        rdy16, vld16, rdy8, vld8, rdy32, vld32;
  logic [31:0] prod16;
  logic [15:0] prod8;
  logic [63:0] prod32;
  logic [3:0]  tag16, tag8, tag32;

  int chk_cnt = 0;
  int pass_cnt = 0;
  bit sb_on = 1'b0;

  typedef struct {
    logic [63:0] p;
    logic [3:0]  tag;
  } exp_t;
  exp_t sbq[3][$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sgn;
    logic [3:0]  tag;
    logic [31:0] exp;
  } vec_t;

  always #5 clk = ~clk;

  mult_comp_pipe #(.W(16), .REG_EVERY(2), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16),
    .in_a(st_a[15:0]), .in_b(st_b[15:0]), .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(vld16), .out_ready(out_ready), .out_prod(prod16), .out_tag(tag16));

  mult_comp_pipe #(.W(8), .REG_EVERY(1), .TAG_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8),
    .in_a(st_a[7:0]), .in_b(st_b[7:0]), .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(vld8), .out_ready(out_ready), .out_prod(prod8), .out_tag(tag8));

  mult_comp_pipe #(.W(32), .REG_EVERY(3), .TAG_W(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
    .in_a(st_a), .in_b(st_b), .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(vld32), .out_ready(out_ready), .out_prod(prod32), .out_tag(tag32));

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                          input logic s, input int w);
    logic [63:0] m, ae, be, p;
    m  = (64'd1 << w) - 64'd1;
    ae = a & m;
    be = b & m;
    if (s && ae[w-1]) ae = ae | ~m;
    if (s && be[w-1]) be = be | ~m;
    p = ae * be;
    if (w < 32) p = p & ((64'd1 << (2*w)) - 64'd1);
    return p;
  endfunction

  task automatic mon(input int id, input int w, input logic ir, input logic ov,
                     input logic [63:0] op, input logic [3:0] ot);
    exp_t e;
    if (in_valid && ir) begin
      e.p   = ref_mul({32'd0, st_a}, {32'd0, st_b}, in_signed, w);
      e.tag = in_tag;
      sbq[id].push_back(e);
    end
    if (ov && out_ready) begin
      if (sbq[id].size() == 0) begin
        check($sformatf("w%0d unexpected output", w), {63'd0, ov}, 64'd0);
      end else begin
        e = sbq[id].pop_front();
        check($sformatf("w%0d random prod", w), op, e.p);
        check($sformatf("w%0d random tag", w), {60'd0, ot}, {60'd0, e.tag});
      end
    end
  endtask

  always @(negedge clk) begin
    if (sb_on) begin
      mon(0, 16, rdy16, vld16, {32'd0, prod16}, tag16);
      mon(1, 8,  rdy8,  vld8,  {48'd0, prod8},  tag8);
      mon(2, 32, rdy32, vld32, prod32,          tag32);
    end
  end

  initial begin
    vec_t        vt[10];
    int          lat, got_n, first_c, last_c;
    bit          ok_a, ok_b, stale, acc;
    logic [31:0] gp[8];
    logic [3:0]  gt[8];
    logic [31:0] hold_p;
    logic [3:0]  hold_t;

    vt[0] = '{16'hFFFF, 16'hFFFF, 1'b0, 4'd3,  32'hFFFE0001};
    vt[1] = '{16'hFFFF, 16'hFFFF, 1'b1, 4'd5,  32'h00000001};
    vt[2] = '{16'h8000, 16'h0001, 1'b1, 4'd6,  32'hFFFF8000};
    vt[3] = '{16'h8000, 16'h8000, 1'b1, 4'd7,  32'h40000000};
    vt[4] = '{16'h8000, 16'h8000, 1'b0, 4'd8,  32'h40000000};
    vt[5] = '{16'h1234, 16'h5678, 1'b0, 4'd9,  32'h06260060};
    vt[6] = '{16'hFFFE, 16'h0003, 1'b1, 4'd10, 32'hFFFFFFFA};
    vt[7] = '{16'h0000, 16'hFFFF, 1'b0, 4'd11, 32'h00000000};
    vt[8] = '{16'h7FFF, 16'h7FFF, 1'b1, 4'd12, 32'h3FFF0001};
    vt[9] = '{16'h7FFF, 16'h8000, 1'b1, 4'd13, 32'hC0008000};

    // Reset state
    #3 rst_n = 1'b0;
    @(negedge clk);
    check("reset out_valid", {63'd0, vld16}, 64'd0);
    check("reset out_prod", {32'd0, prod16}, 64'd0);
    check("reset out_tag", {60'd0, tag16}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Table vectors, one at a time, idle inputs driven to X
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      st_a = {16'd0, vt[i].a}; st_b = {16'd0, vt[i].b};
      in_signed = vt[i].sgn; in_tag = vt[i].tag; in_valid = 1'b1;
      @(posedge clk); lat = 1; #1;
      in_valid = 1'b0; st_a = 'x; st_b = 'x; in_signed = 1'bx; in_tag = 'x;
      @(negedge clk);
      while (!vld16 && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      check($sformatf("vec%0d latency", i), 64'(lat), 64'd5);
      check($sformatf("vec%0d prod", i), {32'd0, prod16}, {32'd0, vt[i].exp});
      check($sformatf("vec%0d tag", i), {60'd0, tag16}, {60'd0, vt[i].tag});
    end

    // Back-to-back: 8 accepts, results must stream out consecutively in order
    ok_a = 1'b1; got_n = 0; first_c = -1; last_c = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          @(posedge clk); #1;
          st_a = 32'(i + 1); st_b = 32'(16'h0101 * (i + 3));
          in_signed = 1'b0; in_tag = 4'(i); in_valid = 1'b1;
          @(negedge clk);
          if (rdy16 !== 1'b1) ok_a = 1'b0;
        end
        @(posedge clk); #1 in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 40 && got_n < 8; c++) begin
          @(negedge clk);
          if (vld16 && out_ready) begin
            gp[got_n] = prod16; gt[got_n] = tag16;
            if (got_n == 0) first_c = c;
            last_c = c;
            got_n++;
          end
        end
      end
    join
    check("b2b in_ready held", {63'd0, ok_a}, 64'd1);
    check("b2b result count", 64'(got_n), 64'd8);
    check("b2b consecutive", 64'(last_c - first_c), 64'd7);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("b2b%0d tag", i), {60'd0, gt[i]}, 64'(i));
      check($sformatf("b2b%0d prod", i), {32'd0, gp[i]},
            ref_mul(64'(i + 1), 64'(16'h0101 * (i + 3)), 1'b0, 16));
    end

    // Backpressure: hold result 4 cycles with a second transaction waiting
    @(posedge clk); #1;
    st_a = 32'h00FF; st_b = 32'h0100; in_signed = 1'b0; in_tag = 4'd9;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0;
    for (int c = 0; c < 20 && !vld16; c++) @(negedge clk);
    check("bp out_valid", {63'd0, vld16}, 64'd1);
    hold_p = prod16; hold_t = tag16;
    ok_a = 1'b1; ok_b = 1'b1;
    for (int s = 0; s < 4; s++) begin
      @(posedge clk); #1;
      if (s == 0) begin
        st_a = 32'h0003; st_b = 32'h0005; in_tag = 4'd10; in_valid = 1'b1;
      end
      @(negedge clk);
      if (rdy16 !== 1'b0) ok_a = 1'b0;
      if (prod16 !== hold_p || tag16 !== hold_t || vld16 !== 1'b1) ok_b = 1'b0;
    end
    check("bp in_ready low", {63'd0, ok_a}, 64'd1);
    check("bp output stable", {63'd0, ok_b}, 64'd1);
    check("bp held prod", {32'd0, hold_p}, 64'h0000FF00);
    @(posedge clk); #1 out_ready = 1'b1;
    got_n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (vld16 && out_ready) begin
        if (got_n < 8) begin
          gp[got_n] = prod16; gt[got_n] = tag16;
        end
        got_n++;
      end
      acc = in_valid && rdy16;
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    check("bp result count", 64'(got_n), 64'd2);
    check("bp first tag", {60'd0, gt[0]}, 64'd9);
    check("bp first prod", {32'd0, gp[0]}, 64'h0000FF00);
    check("bp second tag", {60'd0, gt[1]}, 64'd10);
    check("bp second prod", {32'd0, gp[1]}, 64'd15);

    // Reset mid-flight: one result showing, three more in the pipe
    @(posedge clk); #1;
    st_a = 32'h1111; st_b = 32'h0002; in_tag = 4'd1; in_signed = 1'b0; in_valid = 1'b1;
    for (int i = 1; i < 5; i++) begin
      @(posedge clk); #1;
      st_a = 32'(16'h1111 * (i + 1)); in_tag = 4'(i + 1);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst pre out_valid", {63'd0, vld16}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst out_valid", {63'd0, vld16}, 64'd0);
    check("rst out_prod", {32'd0, prod16}, 64'd0);
    check("rst out_tag", {60'd0, tag16}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (vld16 !== 1'b0) stale = 1'b1;
    end
    check("rst no stale output", {63'd0, stale}, 64'd0);

    // Random sweep across W=16/8/32 with random stalls
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    sb_on = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      st_a      = $urandom;
      st_b      = $urandom;
      in_signed = 1'($urandom_range(0, 1));
      in_tag    = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    check("w16 drained", 64'(sbq[0].size()), 64'd0);
    check("w8 drained", 64'(sbq[1].size()), 64'd0);
    check("w32 drained", 64'(sbq[2].size()), 64'd0);
    sb_on = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
